instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Converse of the main control decoder: packs instruction fields (op class, rs, rt, rd,
//  shamt, imm, target) into 32-bit MIPS words for the supported ISA subset. Buffers the
//  words in a small FIFO and writes them to instruction memory at sequential word
//  addresses. Used as the program loader / self-test generator in front of the IM.
// PARAMETERS
//  ADDR_W     10  IM word-address width; im_addr wraps modulo 2**ADDR_W
//  BASE_ADDR  0   address loaded on reset and on clr
//  DEPTH      4   FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1       clock, all logic rising-edge
//  rst_n      in   1       synchronous active-low reset
//  clr        in   1       sync flush: empty FIFO, im_addr<=BASE_ADDR, clear err_illegal, wr_count<=0
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       room to accept; = (count<DEPTH) && !clr
//  in_op      in   4       0 ADDU,1 SUBU,2 SLT,3 SLL,4 JR,5 LUI,6 ORI,7 LW,8 SW,9 BEQ,10 JAL,11 J,12 SB,13 LH; 14-15 illegal
//  in_rs/in_rt/in_rd  in 5 each  register fields
//  in_shamt   in   5       shift amount (SLL only)
//  in_imm     in   16      immediate/offset (I-type)
//  in_target  in   26      jump target (J/JAL)
//  im_we      out  1       write request; high whenever FIFO non-empty
//  im_ready   in   1       IM accepts write this cycle
//  im_addr    out  ADDR_W  word address of current write
//  im_wdata   out  32      encoded word at FIFO head; 0 when FIFO empty
//  wr_count   out  ADDR_W+1 completed writes since reset/clr, wraps
//  err_illegal out 1       sticky: an illegal in_op was accepted
// BEHAVIOUR
//  Reset (rst_n=0 at edge): FIFO empty, im_we=0, im_wdata=0, im_addr=BASE_ADDR, wr_count=0, err_illegal=0.
//  Accept = in_valid && in_ready. Encoding done combinationally at accept; encoded word stored.
//  R-type {6'h00,rs,rt,rd,shamt,funct}: ADDU f=21h, SUBU 23h, SLT 2Ah (shamt forced 0);
//   SLL f=00h, rs forced 0; JR f=08h, rt/rd/shamt forced 0.
//  I-type {op,rs,rt,imm}: LUI 0Fh (rs forced 0), ORI 0Dh, LW 23h, SW 2Bh, BEQ 04h, SB 28h, LH 21h.
//  J-type {op,target}: J 02h, JAL 03h.
//  Illegal op (14,15): handshake completes, nothing enqueued, err_illegal<=1 next cycle.
//  Latency: word accepted at edge N visible on im_wdata/im_we after edge N (first-word fall-through
//   from registered FIFO storage, no combinational in->out path).
//  Write completes at edge where im_we && im_ready: pop head, im_addr<=im_addr+1 (wrap 2**ADDR_W-1->0),
//   wr_count+=1. im_addr/im_wdata stable while im_we && !im_ready.
//  Simultaneous accept+complete: count unchanged, order preserved. Full: in_ready=0 even if a pop
//   occurs that cycle (no same-cycle pass-through).
//  clr has priority over accept and complete in the same cycle; the pending write is dropped.
//  rst_n mid-transfer: all buffered words discarded, no further im_we until new accept.
//  Internal state: count 0..DEPTH, rd/wr pointers mod DEPTH; no FSM beyond FIFO occupancy.
// TESTING
//  1 ADDU rs=1 rt=2 rd=3, im_ready=1 -> one write 0x00221821 @BASE_ADDR, wr_count=1.
//  2 LUI rt=1 imm=1234h with in_rs=7 -> 0x3C011234; SLL rd=2 rt=3 shamt=4 rs=7 -> 0x00031100.
//  3 JAL target=000C00h -> 0x0C000C00; J target=0 -> 0x08000000; JR rs=31 rd=5 -> 0x03E00008.
//  4 DEPTH=4, im_ready=0, push 5 -> in_ready=0 after 4th accept; release -> addrs 0..3 in order, then 5th.
//  5 ADDR_W=2, 5 writes -> im_addr sequence 0,1,2,3,0; wr_count=5.
//  6 in_op=15 -> no im_we, err_illegal=1 until clr; clr with 2 queued -> im_we=0, im_addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input handshake and instruction-memory write port of the loader.
// The master side is the program source and memory model; the slave side is the loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              im_we;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, im_ready,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, im_ready,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs MIPS instruction fields into 32-bit words, buffers them in a small FIFO and
// streams them to instruction memory at sequential word addresses.
module instr_encoder_loader #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        wr_count,
    output logic                   err_illegal
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WRC_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    // Field-bundle op classes
    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_JR   = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_ORI  = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_JAL  = 4'd10;
    localparam logic [3:0] OP_J    = 4'd11;
    localparam logic [3:0] OP_SB   = 4'd12;
    localparam logic [3:0] OP_LH   = 4'd13;

    // MIPS primary opcodes and R-type function codes
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LH      = 6'h21;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SB      = 6'h28;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OPC_SPECIAL, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

    // Returns {legal, word}; fields an instruction does not use are forced to zero.
    function automatic logic [32:0] encode(input logic [3:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  shamt,
                                           input logic [15:0] imm,
                                           input logic [25:0] target);
        logic [32:0] res;
        res = '0;
        case (op)
            OP_ADDU: res = {1'b1, r_type(rs, rt, rd, 5'd0, FN_ADDU)};
            OP_SUBU: res = {1'b1, r_type(rs, rt, rd, 5'd0, FN_SUBU)};
            OP_SLT:  res = {1'b1, r_type(rs, rt, rd, 5'd0, FN_SLT)};
            OP_SLL:  res = {1'b1, r_type(5'd0, rt, rd, shamt, FN_SLL)};
            OP_JR:   res = {1'b1, r_type(rs, 5'd0, 5'd0, 5'd0, FN_JR)};
            OP_LUI:  res = {1'b1, i_type(OPC_LUI, 5'd0, rt, imm)};
            OP_ORI:  res = {1'b1, i_type(OPC_ORI, rs, rt, imm)};
            OP_LW:   res = {1'b1, i_type(OPC_LW, rs, rt, imm)};
            OP_SW:   res = {1'b1, i_type(OPC_SW, rs, rt, imm)};
            OP_BEQ:  res = {1'b1, i_type(OPC_BEQ, rs, rt, imm)};
            OP_SB:   res = {1'b1, i_type(OPC_SB, rs, rt, imm)};
            OP_LH:   res = {1'b1, i_type(OPC_LH, rs, rt, imm)};
            OP_JAL:  res = {1'b1, j_type(OPC_JAL, target)};
            OP_J:    res = {1'b1, j_type(OPC_J, target)};
            default: res = '0;
        endcase
        return res;
    endfunction

    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_q;

    logic [32:0] enc;
    logic        accept;
    logic        push;
    logic        pop;
    logic        not_empty;

    assign enc       = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                              bus.in_shamt, bus.in_imm, bus.in_target);
    assign not_empty = (count != '0);

    // Readiness depends only on registered occupancy, so a pop never opens a full FIFO
    // within the same cycle.
    assign bus.in_ready = (count < CNT_FULL) && !clr;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && enc[32];
    assign pop          = not_empty && bus.im_ready && !clr;

    assign bus.im_we    = not_empty;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = not_empty ? mem[rd_ptr] : 32'h0;

    // Word storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr_q      <= BASE;
            wr_count    <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                addr_q   <= addr_q + ADDR_W'(1);
                wr_count <= wr_count + WRC_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (accept && !enc[32]) begin
                err_illegal <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized checks of the instruction encoder/loader against a queue-based
// reference model that encodes words with plain integer arithmetic.
module tb_instr_encoder_loader;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int BASE   = 0;

    logic            clk;
    logic            rst_n;
    logic            clr;
    logic [ADDR_W:0] wr_count;
    logic            err_illegal;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .bus(bus),
        .wr_count(wr_count),
        .err_illegal(err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq[$];
    int          m_addr = BASE;
    int          m_wrc  = 0;
    bit          m_err  = 0;
    bit          m_acc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: {legal, word} built from field values with integer weights.
    function automatic logic [32:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
        longint opc;
        int     fn;
        bit     is_r;
        bit     is_j;
        opc = 0; fn = 0; is_r = 0; is_j = 0;
        case (op)
            0:  begin is_r = 1; fn = 'h21; sh = 0; end
            1:  begin is_r = 1; fn = 'h23; sh = 0; end
            2:  begin is_r = 1; fn = 'h2A; sh = 0; end
            3:  begin is_r = 1; fn = 'h00; rs = 0; end
            4:  begin is_r = 1; fn = 'h08; rt = 0; rd = 0; sh = 0; end
            5:  begin opc = 'h0F; rs = 0; end
            6:  opc = 'h0D;
            7:  opc = 'h23;
            8:  opc = 'h2B;
            9:  opc = 'h04;
            12: opc = 'h28;
            13: opc = 'h21;
            10: begin is_j = 1; opc = 3; end
            11: begin is_j = 1; opc = 2; end
            default: return 33'h0;
        endcase
        if (is_j) return {1'b1, 32'(opc * 64'd67108864 + longint'(tgt))};
        if (is_r) return {1'b1, 32'(longint'(rs) * 2097152 + longint'(rt) * 65536
                                    + longint'(rd) * 2048 + longint'(sh) * 64 + longint'(fn))};
        return {1'b1, 32'(opc * 64'd67108864 + longint'(rs) * 2097152
                          + longint'(rt) * 65536 + longint'(imm))};
    endfunction

    task automatic set_in(input int v, input int op, input int rs, input int rt, input int rd,
                          input int sh, input int imm, input int tgt);
        bus.in_valid  = v[0];
        bus.in_op     = 4'(op);
        bus.in_rs     = 5'(rs);
        bus.in_rt     = 5'(rt);
        bus.in_rd     = 5'(rd);
        bus.in_shamt  = 5'(sh);
        bus.in_imm    = 16'(imm);
        bus.in_target = 26'(tgt);
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH && !clr));
        chk("im_we", 32'(bus.im_we), 32'(mq.size() != 0));
        chk("im_wdata", bus.im_wdata, (mq.size() != 0) ? mq[0] : 32'h0);
        chk("im_addr", 32'(bus.im_addr), 32'(m_addr));
        chk("wr_count", 32'(wr_count), 32'(m_wrc));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
    endtask

    // One clock: check outputs on the falling edge, then advance the model at the rising edge.
    task automatic step();
        logic [32:0] e;
        bit          cmp;
        @(negedge clk);
        check_outputs();
        m_acc = bus.in_valid && (mq.size() < DEPTH) && !clr;
        cmp   = (mq.size() != 0) && bus.im_ready;
        e = ref_word(int'(bus.in_op), int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                     int'(bus.in_shamt), int'(bus.in_imm), int'(bus.in_target));
        @(posedge clk);
        if (!rst_n || clr) begin
            mq.delete();
            m_addr = BASE;
            m_wrc  = 0;
            m_err  = 0;
            m_acc  = 0;
        end else begin
            if (cmp) begin
                void'(mq.pop_front());
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                m_wrc  = (m_wrc + 1) % (1 << (ADDR_W + 1));
            end
            if (m_acc) begin
                if (e[32]) mq.push_back(e[31:0]);
                else       m_err = 1;
            end
        end
        #1;
    endtask

    task automatic push_random_legal();
        set_in(1, $urandom_range(0, 13), int'($urandom), int'($urandom), int'($urandom),
               int'($urandom), int'($urandom), int'($urandom));
    endtask

    int          d_op [6] = '{0, 5, 3, 10, 11, 4};
    int          d_rs [6] = '{1, 7, 7, 0, 0, 31};
    int          d_rt [6] = '{2, 1, 3, 0, 0, 0};
    int          d_rd [6] = '{3, 0, 2, 0, 0, 5};
    int          d_sh [6] = '{0, 0, 4, 0, 0, 0};
    int          d_imm[6] = '{0, 'h1234, 0, 0, 0, 0};
    int          d_tgt[6] = '{0, 0, 0, 'hC00, 0, 0};
    logic [31:0] d_exp[6] = '{32'h00221821, 32'h3C011234, 32'h00031100,
                              32'h0C000C00, 32'h08000000, 32'h03E00008};
    int          got[$];

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.im_ready = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_im_we", 32'(bus.im_we), 32'h0);
        chk("rst_im_wdata", bus.im_wdata, 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        rst_n = 1'b1;
        step();

        // Directed encodings, one word at a time, each written on the following cycle.
        for (int i = 0; i < 6; i++) begin
            bus.im_ready = 1'b0;
            set_in(1, d_op[i], d_rs[i], d_rt[i], d_rd[i], d_sh[i], d_imm[i], d_tgt[i]);
            step();
            bus.in_valid = 1'b0;
            chk("enc_word", bus.im_wdata, d_exp[i]);
            chk("enc_addr", 32'(bus.im_addr), 32'(i % 4));
            bus.im_ready = 1'b1;
            step();
            chk("enc_wr_count", 32'(wr_count), 32'(i + 1));
            chk("enc_drained", 32'(bus.im_we), 32'h0);
        end

        // Fill to DEPTH with memory stalled, then drain: address order 0,1,2,3,0.
        clr = 1'b1;
        step();
        clr = 1'b0;
        bus.im_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_random_legal();
            step();
        end
        push_random_legal();
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        step();
        bus.im_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            if (bus.im_we) got.push_back(int'(bus.im_addr));
            step();
            if (m_acc) bus.in_valid = 1'b0;
        end
        chk("drain_count", 32'(got.size()), 32'd5);
        for (int k = 0; k < got.size() && k < 5; k++) chk("addr_seq", 32'(got[k]), 32'(k % 4));
        chk("drain_wr_count", 32'(wr_count), 32'd5);

        // Illegal op: handshake completes, nothing written, sticky error until clr.
        bus.im_ready = 1'b0;
        set_in(1, 15, 1, 2, 3, 4, 5, 6);
        chk("illegal_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("illegal_no_we", 32'(bus.im_we), 32'h0);
        chk("illegal_err", 32'(err_illegal), 32'h1);
        set_in(1, 14, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            push_random_legal();
            step();
        end
        bus.in_valid = 1'b0;
        chk("err_sticky", 32'(err_illegal), 32'h1);
        push_random_legal();
        clr = 1'b1;
        bus.im_ready = 1'b1;
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_im_we", 32'(bus.im_we), 32'h0);
        chk("clr_addr", 32'(bus.im_addr), 32'(BASE));
        chk("clr_err", 32'(err_illegal), 32'h0);
        chk("clr_wr_count", 32'(wr_count), 32'h0);

        // Reset in the middle of a stalled transfer discards the buffered words.
        bus.im_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_random_legal();
            step();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.im_ready = 1'b1;
        chk("rst_mid_we", 32'(bus.im_we), 32'h0);
        step();
        step();

        // Random traffic, including illegal ops, stalls and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 15), int'($urandom), int'($urandom),
                   int'($urandom), int'($urandom), int'($urandom), int'($urandom));
            bus.im_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            step();
        end
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.im_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("final_empty", 32'(bus.im_we), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
